// File: rtl/fp16_divider_if.sv
// Operand/result handshake bundle for the iterative FP16 divider.
// The master drives the operands and accepts results; the slave is the divider.
interface fp16_divider_if #(
  parameter int unsigned DWIDTH = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] a;
  logic [DWIDTH-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] result;
  logic [4:0]        flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp16_divider.sv
// Iterative binary16 divider: result = a / b.
// Radix-2 restoring mantissa division (one quotient bit per cycle), then
// round-to-nearest-even. Special operands are resolved up front and carried
// through the same fixed-length pipeline so latency never depends on data.
// Flags: [4] invalid, [3] divide-by-zero, [2] overflow, [1] underflow, [0] inexact.
module fp16_divider #(
  parameter int unsigned EXPONENT = 5,
  parameter int unsigned MANTISSA = 10,
  parameter int unsigned BIAS     = 15,
  parameter int unsigned DWIDTH   = 1 + EXPONENT + MANTISSA
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fp16_divider_if.slave io_div
);

  localparam int unsigned MW = MANTISSA + 1;  // mantissa with hidden bit
  localparam int unsigned RW = MANTISSA + 2;  // partial remainder
  localparam int unsigned QW = MANTISSA + 3;  // quotient bits produced
  localparam int unsigned EW = EXPONENT + 2;  // signed exponent working width
  localparam int unsigned CW = $clog2(QW);
  localparam logic [EW-1:0] ExpMax  = EW'((1 << EXPONENT) - 1);
  localparam logic [EW-1:0] ExpBias = EW'(BIAS);

  typedef enum logic [2:0] {StIdle, StUnpack, StDivide, StRound, StDone} state_e;

  state_e r_state, w_state_next;

  logic [DWIDTH-1:0] r_a, r_b;
  logic              r_sign;
  logic              r_special;
  logic [DWIDTH-1:0] r_spec_res;
  logic [4:0]        r_spec_flags;
  logic [MW-1:0]     r_mb;
  logic [RW-1:0]     r_rem;
  logic [QW-1:0]     r_q;
  logic [CW-1:0]     r_cnt;
  logic [EW-1:0]     r_exp;
  logic [DWIDTH-1:0] r_result;
  logic [4:0]        r_flags;

  logic w_in_fire;
  assign w_in_fire = io_div.in_valid && (r_state == StIdle);

  assign io_div.in_ready  = (r_state == StIdle);
  assign io_div.out_valid = (r_state == StDone);
  assign io_div.result    = r_result;
  assign io_div.flags     = r_flags;

  // Operand field extraction and classification (subnormals read as zero).
  logic [EXPONENT-1:0] w_ea, w_eb;
  logic [MANTISSA-1:0] w_fa, w_fb;
  logic w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan, w_sign;

  assign w_ea     = r_a[DWIDTH-2 -: EXPONENT];
  assign w_eb     = r_b[DWIDTH-2 -: EXPONENT];
  assign w_fa     = r_a[MANTISSA-1:0];
  assign w_fb     = r_b[MANTISSA-1:0];
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (&w_ea) && (w_fa == '0);
  assign w_b_inf  = (&w_eb) && (w_fb == '0);
  assign w_a_nan  = (&w_ea) && (w_fa != '0);
  assign w_b_nan  = (&w_eb) && (w_fb != '0);
  assign w_sign   = r_a[DWIDTH-1] ^ r_b[DWIDTH-1];

  logic [DWIDTH-1:0] w_qnan, w_inf, w_zero;
  assign w_qnan = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
  assign w_inf  = {w_sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
  assign w_zero = {w_sign, {(DWIDTH-1){1'b0}}};

  logic [EW-1:0] w_exp_diff;
  assign w_exp_diff = {2'b00, w_ea} - {2'b00, w_eb} + ExpBias;

  // Special-operand resolution; Inf/0 is Inf/finite, so Inf on a is tested first.
  logic              w_spec;
  logic [DWIDTH-1:0] w_spec_res;
  logic [4:0]        w_spec_flags;
  always_comb begin
    w_spec       = 1'b1;
    w_spec_res   = '0;
    w_spec_flags = '0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_res   = w_qnan;
      w_spec_flags = 5'b10000;
    end else if (w_a_inf) begin
      w_spec_res = w_inf;
    end else if (w_b_zero) begin
      w_spec_res   = w_inf;
      w_spec_flags = 5'b01000;
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = w_zero;
    end else begin
      w_spec = 1'b0;
    end
  end

  // One restoring step: compare, conditionally subtract, shift.
  logic          w_qbit;
  logic [RW-1:0] w_rem_sub, w_rem_next;
  assign w_qbit     = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub  = w_qbit ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // Normalise, round to nearest even and range-check the finished quotient.
  logic                w_q_hi, w_guard, w_sticky, w_inc, w_inexact, w_ovf, w_unf;
  logic [MANTISSA-1:0] w_mant_pre, w_mant_rnd;
  logic [MANTISSA:0]   w_mant_sum;
  logic [EW-1:0]       w_exp_pre, w_exp_rnd;
  logic [DWIDTH-1:0]   w_rnd_res;
  logic [4:0]          w_rnd_flags;
  always_comb begin
    w_q_hi     = r_q[QW-1];
    w_mant_pre = w_q_hi ? r_q[QW-2:2] : r_q[QW-3:1];
    w_guard    = w_q_hi ? r_q[1] : r_q[0];
    w_sticky   = (w_q_hi && r_q[0]) || (r_rem != '0);
    w_exp_pre  = w_q_hi ? r_exp : (r_exp - {{(EW-1){1'b0}}, 1'b1});
    w_inc      = w_guard && (w_sticky || w_mant_pre[0]);
    w_mant_sum = {1'b0, w_mant_pre} + {{MANTISSA{1'b0}}, w_inc};
    // A carry out leaves the low bits at zero, which is the wrapped mantissa.
    w_mant_rnd = w_mant_sum[MANTISSA-1:0];
    w_exp_rnd  = w_exp_pre + {{(EW-1){1'b0}}, w_mant_sum[MANTISSA]};
    w_inexact  = w_guard || w_sticky;
    w_ovf      = !w_exp_rnd[EW-1] && (w_exp_rnd >= ExpMax);
    w_unf      = w_exp_rnd[EW-1] || (w_exp_rnd == '0);
    w_rnd_res   = {r_sign, w_exp_rnd[EXPONENT-1:0], w_mant_rnd};
    w_rnd_flags = {4'b0000, w_inexact};
    if (w_ovf) begin
      w_rnd_res   = {r_sign, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      w_rnd_flags = 5'b00101;
    end else if (w_unf) begin
      w_rnd_res   = {r_sign, {(DWIDTH-1){1'b0}}};
      w_rnd_flags = 5'b00011;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // FSM next-state: fixed-length walk from UNPACK to DONE for every operand class.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_in_fire) w_state_next = StUnpack;
      StUnpack: w_state_next = StDivide;
      StDivide: if (r_cnt == '0) w_state_next = StRound;
      StRound:  w_state_next = StDone;
      StDone:   if (io_div.out_ready) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // Datapath registers, advanced per state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_sign       <= 1'b0;
      r_special    <= 1'b0;
      r_spec_res   <= '0;
      r_spec_flags <= '0;
      r_mb         <= '0;
      r_rem        <= '0;
      r_q          <= '0;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_result     <= '0;
      r_flags      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_in_fire) begin
            r_a <= io_div.a;
            r_b <= io_div.b;
          end
        end
        StUnpack: begin
          r_sign       <= w_sign;
          r_special    <= w_spec;
          r_spec_res   <= w_spec_res;
          r_spec_flags <= w_spec_flags;
          r_mb         <= {1'b1, w_fb};
          r_rem        <= {2'b01, w_fa};
          r_q          <= '0;
          r_cnt        <= CW'(QW - 1);
          r_exp        <= w_exp_diff;
        end
        StDivide: begin
          r_rem <= w_rem_next;
          r_q   <= {r_q[QW-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        StRound: begin
          r_result <= r_special ? r_spec_res : w_rnd_res;
          r_flags  <= r_special ? r_spec_flags : w_rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider.sv
// Self-checking bench for fp16_divider: directed vector table, handshake and
// reset sequences, then random operands against an arithmetic reference model.
module tb_fp16_divider;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_divider_if u_if ();

  fp16_divider u_dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_div (u_if)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient and remainder, rounded to nearest even.
  function automatic logic [20:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, ma, mb, e, m, r, num;
    logic s, an, bn, az, bz, ai, bi, inx;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    az = (ea == 0); bz = (eb == 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    if (an || bn || (az && bz) || (ai && bi)) return {5'h10, 16'h7E00};
    if (ai) return {5'h00, s, 15'h7C00};
    if (bz) return {5'h08, s, 15'h7C00};
    if (bi || az) return {5'h00, s, 15'h0000};
    ma = 1024 + fa;
    mb = 1024 + fb;
    e  = ea - eb + 15;
    if (ma >= mb) num = ma * 1024;
    else begin
      num = ma * 2048;
      e   = e - 1;
    end
    m   = num / mb;
    r   = num % mb;
    inx = (r != 0);
    if ((2 * r > mb) || ((2 * r == mb) && (m % 2 == 1))) m = m + 1;
    if (m == 2048) begin
      m = 1024;
      e = e + 1;
    end
    if (e >= 31) return {5'h05, s, 15'h7C00};
    if (e <= 0)  return {5'h03, s, 15'h0000};
    return {4'b0000, inx, s, 5'(e), 10'(m - 1024)};
  endfunction

  // Wait (bounded) for out_valid; lat counts edges since the accepting edge.
  task automatic wait_out(output int lat, output bit busy_bad);
    lat      = -1;
    busy_bad = 1'b0;
    for (int j = 0; j <= 40; j++) begin
      if (u_if.out_valid) begin
        lat = j;
        break;
      end
      if (u_if.in_ready) busy_bad = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Issue one operation, stall the result for 'hold' cycles, then accept it.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                       output logic [15:0] res, output logic [4:0] flg,
                       output int lat, output bit busy_bad, output bit hs_bad);
    hs_bad        = 1'b0;
    u_if.a        = a;
    u_if.b        = b;
    u_if.in_valid = 1'b1;
    u_if.out_ready = 1'b0;
    for (int j = 0; j < 40 && !u_if.in_ready; j++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    u_if.a        = 16'($urandom);
    u_if.b        = 16'($urandom);
    wait_out(lat, busy_bad);
    res = u_if.result;
    flg = u_if.flags;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!u_if.out_valid || u_if.in_ready || u_if.result !== res || u_if.flags !== flg)
        hs_bad = 1'b1;
    end
    u_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.out_ready = 1'b0;
    if (u_if.out_valid || !u_if.in_ready) hs_bad = 1'b1;
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 11))
      0: v = {v[15], 15'h0000};
      1: v = {v[15], 15'h7C00};
      2: v = {v[15], 5'h1F, 10'(v[9:0] | 10'h001)};
      3: v = {v[15], 5'h00, v[9:0]};
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] res;
    logic [4:0]  flg;
    logic [20:0] exp_v;
    logic [15:0] ra, rb;
    int          lat, ov_seen;
    bit          busy_bad, hs_bad;

    vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, 5'h00};
    vecs[1]  = '{16'h4200, 16'h4000, 16'h3E00, 5'h00};
    vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, 5'h01};
    vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, 5'h08};
    vecs[4]  = '{16'hBC00, 16'h0000, 16'hFC00, 5'h08};
    vecs[5]  = '{16'h0000, 16'h0000, 16'h7E00, 5'h10};
    vecs[6]  = '{16'h7C00, 16'h7C00, 16'h7E00, 5'h10};
    vecs[7]  = '{16'h7BFF, 16'h1400, 16'h7C00, 5'h05};
    vecs[8]  = '{16'h0400, 16'h4000, 16'h0000, 5'h03};
    vecs[9]  = '{16'hC000, 16'h4000, 16'hBC00, 5'h00};
    vecs[10] = '{16'h7C00, 16'h3C00, 16'h7C00, 5'h00};
    vecs[11] = '{16'h3C00, 16'hFC00, 16'h8000, 5'h00};
    vecs[12] = '{16'h0000, 16'h3C00, 16'h0000, 5'h00};
    vecs[13] = '{16'h7E01, 16'h3C00, 16'h7E00, 5'h10};
    vecs[14] = '{16'h0001, 16'h3C00, 16'h0000, 5'h00};
    vecs[15] = '{16'h3C00, 16'h0001, 16'h7C00, 5'h08};
    vecs[16] = '{16'h7C00, 16'h0000, 16'h7C00, 5'h00};
    vecs[17] = '{16'h8000, 16'h3C00, 16'h8000, 5'h00};

    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    u_if.a         = '0;
    u_if.b         = '0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(u_if.in_ready), 32'd1);
    check("reset out_valid", 32'(u_if.out_valid), 32'd0);
    check("reset result", 32'(u_if.result), 32'h0);
    check("reset flags", 32'(u_if.flags), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table; the first vector also stalls the result for 5 cycles.
    for (int i = 0; i < 18; i++) begin
      do_op(vecs[i].a, vecs[i].b, (i == 0) ? 5 : i % 3, res, flg, lat, busy_bad, hs_bad);
      check($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d flags", i), 32'(flg), 32'(vecs[i].flg));
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd15);
      check($sformatf("vec%0d busy in_ready", i), 32'(busy_bad), 32'd0);
      check($sformatf("vec%0d handshake", i), 32'(hs_bad), 32'd0);
    end

    // Operands changing while busy are ignored; in_valid held across the
    // output transfer is taken on the following IDLE cycle.
    u_if.a = 16'h4200; u_if.b = 16'h4000; u_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.a = 16'h3C00; u_if.b = 16'h4200;
    wait_out(lat, busy_bad);
    check("busy ignore result", 32'(u_if.result), 32'h3E00);
    check("busy ignore latency", 32'(lat), 32'd15);
    check("busy in_ready", 32'(busy_bad), 32'd0);
    u_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.out_ready = 1'b0;
    check("overlap out_valid dropped", 32'(u_if.out_valid), 32'd0);
    check("overlap idle in_ready", 32'(u_if.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    wait_out(lat, busy_bad);
    check("overlap second latency", 32'(lat), 32'd15);
    check("overlap second result", 32'(u_if.result), 32'h3555);
    check("overlap second flags", 32'(u_if.flags), 32'h01);
    u_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.out_ready = 1'b0;

    // Reset during the sixth DIVIDE cycle aborts the operation.
    u_if.a = 16'h3C00; u_if.b = 16'h4200; u_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready", 32'(u_if.in_ready), 32'd1);
    check("midrst out_valid", 32'(u_if.out_valid), 32'd0);
    check("midrst result", 32'(u_if.result), 32'h0);
    check("midrst flags", 32'(u_if.flags), 32'h0);
    ov_seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (u_if.out_valid) ov_seen++;
    end
    check("midrst out_valid never", 32'(ov_seen), 32'd0);
    do_op(16'h4200, 16'h4000, 1, res, flg, lat, busy_bad, hs_bad);
    check("after rst result", 32'(res), 32'h3E00);
    check("after rst flags", 32'(flg), 32'h00);
    check("after rst latency", 32'(lat), 32'd15);

    // Random operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra    = pick_operand();
      rb    = pick_operand();
      exp_v = ref_div(ra, rb);
      do_op(ra, rb, $urandom_range(0, 2), res, flg, lat, busy_bad, hs_bad);
      if ({flg, res} !== exp_v)
        $display("  operands a=0x%04h b=0x%04h", ra, rb);
      check($sformatf("rand%0d flags_result", i), 32'({flg, res}), 32'(exp_v));
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd15);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
